mastermind_ctrl: RTL and testbench



---
 rtl/mastermind_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mastermind_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_ctrl.sv
// Mastermind game sequencer: peg editing from button pulses, 6x4 guess matrix,
// and a six-cycle colour-by-colour scorer producing black/white feedback per row.
module mastermind_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] secret,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_enter,
    output logic [71:0] matrix_flat,
    output logic [2:0]  guess_num,
    output logic        q_Input,
    output logic [1:0]  cursor,
    output logic [35:0] feedback_flat,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {IDLE, INPUT, CHECK, WIN, LOSE} state_t;

    state_t      state_q, state_d;
    logic [71:0] matrix_q, matrix_d;
    logic [35:0] feedback_q, feedback_d;
    logic [11:0] secret_q, secret_d;
    logic [2:0]  guess_q, guess_d;
    logic [1:0]  cursor_q, cursor_d;
    logic [2:0]  k_q, k_d;
    logic [2:0]  sum_q, sum_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic        q_input_q, q_input_d;

    function automatic logic [2:0] count_colour(input logic [11:0] code, input logic [2:0] colour);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (code[i*3 +: 3] == colour) n = n + 3'd1;
        end
        return n;
    endfunction

    function automatic logic [2:0] count_black(input logic [11:0] guess, input logic [11:0] code);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (guess[i*3 +: 3] == code[i*3 +: 3]) n = n + 3'd1;
        end
        return n;
    endfunction

    logic        secret_ok;
    logic [6:0]  row_base;
    logic [6:0]  peg_base;
    logic [5:0]  fb_base;
    logic [2:0]  cur_peg;
    logic [11:0] cur_row;
    logic        row_full;
    logic [2:0]  colour;
    logic [2:0]  cnt_guess;
    logic [2:0]  cnt_secret;
    logic [2:0]  black;
    logic [2:0]  white;

    always_comb begin
        secret_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (secret[i*3 +: 3] == 3'd0 || secret[i*3 +: 3] == 3'd7) secret_ok = 1'b0;
        end
    end

    assign row_base   = 7'(guess_q) * 7'd12;
    assign peg_base   = row_base + 7'(cursor_q) * 7'd3;
    assign fb_base    = 6'(guess_q) * 6'd6;
    assign cur_peg    = matrix_q[peg_base +: 3];
    assign cur_row    = matrix_q[row_base +: 12];
    assign row_full   = (cur_row[2:0] != 3'd0) && (cur_row[5:3] != 3'd0) &&
                        (cur_row[8:6] != 3'd0) && (cur_row[11:9] != 3'd0);
    assign colour     = k_q + 3'd1;
    assign cnt_guess  = count_colour(cur_row, colour);
    assign cnt_secret = count_colour(secret_q, colour);
    assign black      = count_black(cur_row, secret_q);
    assign white      = sum_q - black;

    // Next-state logic; a valid start overrides everything, including an in-flight check.
    always_comb begin
        state_d    = state_q;
        matrix_d   = matrix_q;
        feedback_d = feedback_q;
        secret_d   = secret_q;
        guess_d    = guess_q;
        cursor_d   = cursor_q;
        k_d        = k_q;
        sum_d      = sum_q;
        win_d      = win_q;
        lose_d     = lose_q;
        if (start && secret_ok) begin
            state_d    = INPUT;
            matrix_d   = '0;
            feedback_d = '0;
            secret_d   = secret;
            guess_d    = '0;
            cursor_d   = '0;
            k_d        = '0;
            sum_d      = '0;
            win_d      = 1'b0;
            lose_d     = 1'b0;
        end else begin
            case (state_q)
                INPUT: begin
                    if (btn_enter) begin
                        if (row_full) begin
                            state_d = CHECK;
                            k_d     = '0;
                            sum_d   = '0;
                        end
                    end else if (btn_up) begin
                        matrix_d[peg_base +: 3] = (cur_peg == 3'd6) ? 3'd1 : cur_peg + 3'd1;
                    end else if (btn_down) begin
                        matrix_d[peg_base +: 3] = (cur_peg <= 3'd1) ? 3'd6 : cur_peg - 3'd1;
                    end else if (btn_left) begin
                        cursor_d = cursor_q - 2'd1;
                    end else if (btn_right) begin
                        cursor_d = cursor_q + 2'd1;
                    end
                end
                // Cycles k=0..5 accumulate per-colour overlap; the seventh cycle closes the row.
                CHECK: begin
                    if (k_q != 3'd6) begin
                        sum_d = sum_q + ((cnt_guess < cnt_secret) ? cnt_guess : cnt_secret);
                        k_d   = k_q + 3'd1;
                    end else begin
                        feedback_d[fb_base +: 6] = {white, black};
                        if (black == 3'd4) begin
                            state_d = WIN;
                            win_d   = 1'b1;
                        end else if (guess_q == 3'd5) begin
                            state_d = LOSE;
                            lose_d  = 1'b1;
                        end else begin
                            state_d  = INPUT;
                            guess_d  = guess_q + 3'd1;
                            cursor_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
        q_input_d = (state_d == INPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            matrix_q   <= '0;
            feedback_q <= '0;
            secret_q   <= '0;
            guess_q    <= '0;
            cursor_q   <= '0;
            k_q        <= '0;
            sum_q      <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            q_input_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            matrix_q   <= matrix_d;
            feedback_q <= feedback_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            cursor_q   <= cursor_d;
            k_q        <= k_d;
            sum_q      <= sum_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            q_input_q  <= q_input_d;
        end
    end

    assign matrix_flat   = matrix_q;
    assign feedback_flat = feedback_q;
    assign guess_num     = guess_q;
    assign cursor        = cursor_q;
    assign q_Input       = q_input_q;
    assign win           = win_q;
    assign lose          = lose_q;

endmodule

// File: tb/tb_mastermind_ctrl.sv
// Self-checking bench for mastermind_ctrl: directed game scenarios plus random
// games scored against a plain rule-based model of the board.
module tb_mastermind_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] secret = '0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_enter = 1'b0;
    logic [71:0] matrix_flat;
    logic [2:0]  guess_num;
    logic        q_Input;
    logic [1:0]  cursor;
    logic [35:0] feedback_flat;
    logic        win, lose;

    int checks = 0;
    int passes = 0;

    mastermind_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .secret(secret),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_enter(btn_enter),
        .matrix_flat(matrix_flat), .guess_num(guess_num), .q_Input(q_Input),
        .cursor(cursor), .feedback_flat(feedback_flat), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Reference board: pegs, feedback, current row and status flags.
    int mm[6][4];
    int mb[6], mw[6];
    int msec[4];
    int mguess, mcursor;
    bit minput, mwin, mlose;

    task automatic model_clear();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) mm[r][c] = 0;
            mb[r] = 0; mw[r] = 0;
        end
        mguess = 0; mcursor = 0; minput = 0; mwin = 0; mlose = 0;
    endtask

    task automatic model_btn(input int b);
        if (minput) begin
            case (b)
                1: mm[mguess][mcursor] = (mm[mguess][mcursor] == 6) ? 1 : mm[mguess][mcursor] + 1;
                2: mm[mguess][mcursor] = (mm[mguess][mcursor] <= 1) ? 6 : mm[mguess][mcursor] - 1;
                3: mcursor = (mcursor + 3) % 4;
                4: mcursor = (mcursor + 1) % 4;
                default: ;
            endcase
        end
    endtask

    task automatic model_close();
        int bl, tot, cg, cs;
        bl = 0; tot = 0;
        for (int c = 0; c < 4; c++) if (mm[mguess][c] == msec[c]) bl++;
        for (int col = 1; col <= 6; col++) begin
            cg = 0; cs = 0;
            for (int c = 0; c < 4; c++) begin
                if (mm[mguess][c] == col) cg++;
                if (msec[c] == col) cs++;
            end
            tot += (cg < cs) ? cg : cs;
        end
        mb[mguess] = bl; mw[mguess] = tot - bl;
        if (bl == 4) begin
            mwin = 1; minput = 0;
        end else if (mguess == 5) begin
            mlose = 1; minput = 0;
        end else begin
            mguess++; mcursor = 0; minput = 1;
        end
    endtask

    function automatic logic [71:0] exp_matrix();
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 4; c++) v[r*12 + c*3 +: 3] = 3'(mm[r][c]);
        return v;
    endfunction

    function automatic logic [35:0] exp_fb();
        logic [35:0] v;
        v = '0;
        for (int r = 0; r < 6; r++) v[r*6 +: 6] = {3'(mw[r]), 3'(mb[r])};
        return v;
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_enter = v;
            1: btn_up    = v;
            2: btn_down  = v;
            3: btn_left  = v;
            4: btn_right = v;
            default: ;
        endcase
    endtask

    task automatic press(input int b);
        @(negedge clk); set_btn(b, 1'b1);
        @(negedge clk); set_btn(b, 1'b0);
        if (b != 0) model_btn(b);
    endtask

    task automatic do_start(input logic [11:0] s);
        bit ok;
        @(negedge clk); start = 1'b1; secret = s;
        @(negedge clk); start = 1'b0;
        ok = 1;
        for (int c = 0; c < 4; c++) if (s[c*3 +: 3] == 3'd0 || s[c*3 +: 3] == 3'd7) ok = 0;
        if (ok) begin
            model_clear();
            minput = 1;
            for (int c = 0; c < 4; c++) msec[c] = int'(s[c*3 +: 3]);
        end
    endtask

    task automatic fill_row(input logic [11:0] code);
        int v;
        for (int c = 0; c < 4; c++) begin
            v = int'(code[c*3 +: 3]);
            if ($urandom_range(1, 0) == 1) repeat (v) press(1);
            else repeat (7 - v) press(2);
            press(4);
        end
    endtask

    // Fills and submits a row, dropping one random button into the check window.
    task automatic play_row(input logic [11:0] code, output logic q_e, output logic q_e6,
                            output logic [35:0] fb_e6, output logic [35:0] fb_pre);
        int b;
        fill_row(code);
        fb_pre = exp_fb();
        press(0);
        q_e = q_Input;
        b = int'($urandom_range(4, 1));
        @(negedge clk); set_btn(b, 1'b1);
        @(negedge clk); set_btn(b, 1'b0);
        repeat (4) @(negedge clk);
        fb_e6 = feedback_flat;
        q_e6 = q_Input;
        @(negedge clk);
        model_close();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        checks++; if ({matrix_flat, feedback_flat, guess_num, cursor, q_Input, win, lose} !== '0)
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {matrix_flat, feedback_flat, guess_num, cursor, q_Input, win, lose});
        else passes++;
        rst_n = 1'b1;
        press(1);
        checks++; if (q_Input !== 1'b0 || matrix_flat !== '0)
            $display("[TB] FAIL idle_ignores_buttons: q_Input %b matrix %h required 0/0", q_Input, matrix_flat);
        else passes++;
    endtask

    task automatic test_win();
        logic q_e, q_e6; logic [35:0] fb_e6, fb_pre;
        do_start(12'o4321);
        checks++; if (q_Input !== 1'b1) $display("[TB] FAIL start_q_input: got %b required 1", q_Input);
        else passes++;
        play_row(12'o4321, q_e, q_e6, fb_e6, fb_pre);
        checks++; if (q_e !== 1'b0 || q_e6 !== 1'b0) $display("[TB] FAIL check_q_low: got %b%b required 00", q_e, q_e6);
        else passes++;
        checks++; if (fb_e6 !== 36'd0) $display("[TB] FAIL fb_before_close: got %h required 0", fb_e6);
        else passes++;
        checks++; if (feedback_flat[5:0] !== 6'd4) $display("[TB] FAIL win_feedback: got %h required 04", feedback_flat[5:0]);
        else passes++;
        checks++; if ({win, lose, q_Input, guess_num} !== 6'b100_000)
            $display("[TB] FAIL win_status: got %b required 100000", {win, lose, q_Input, guess_num});
        else passes++;
        press(1); press(4);
        checks++; if (matrix_flat !== exp_matrix() || cursor !== 2'd0)
            $display("[TB] FAIL win_ignores_buttons: matrix %h cursor %0d required %h 0", matrix_flat, cursor, exp_matrix());
        else passes++;
    endtask

    task automatic test_white_and_mixed();
        logic q_e, q_e6; logic [35:0] fb_e6, fb_pre;
        do_start(12'o4321);
        checks++; if (win !== 1'b0 || feedback_flat !== '0 || matrix_flat !== '0)
            $display("[TB] FAIL restart_clears: win %b fb %h matrix %h required cleared", win, feedback_flat, matrix_flat);
        else passes++;
        play_row(12'o1234, q_e, q_e6, fb_e6, fb_pre);
        checks++; if (feedback_flat[5:0] !== 6'd32) $display("[TB] FAIL white4_feedback: got %h required 20", feedback_flat[5:0]);
        else passes++;
        checks++; if ({guess_num, q_Input, cursor} !== 6'b001_1_00)
            $display("[TB] FAIL white4_status: got %b required 001100", {guess_num, q_Input, cursor});
        else passes++;
        play_row(12'o2211, q_e, q_e6, fb_e6, fb_pre);
        checks++; if (feedback_flat[11:0] !== {6'd9, 6'd32})
            $display("[TB] FAIL mixed_feedback: got %h required 260", feedback_flat[11:0]);
        else passes++;
        checks++; if (matrix_flat !== exp_matrix()) $display("[TB] FAIL mixed_matrix: got %h required %h", matrix_flat, exp_matrix());
        else passes++;
    endtask

    task automatic test_enter_ignored();
        do_start(12'o6543);
        press(1); press(4); press(1); press(1); press(4); press(1); press(1); press(1); press(4);
        press(0);
        repeat (9) @(negedge clk);
        checks++; if ({q_Input, guess_num, cursor} !== 6'b1_000_11)
            $display("[TB] FAIL enter_ignored_state: got %b required 100011", {q_Input, guess_num, cursor});
        else passes++;
        checks++; if (feedback_flat !== '0 || matrix_flat !== exp_matrix())
            $display("[TB] FAIL enter_ignored_data: fb %h matrix %h required 0 %h", feedback_flat, matrix_flat, exp_matrix());
        else passes++;
    endtask

    task automatic test_peg_wrap();
        do_start(12'o1111);
        press(2);
        checks++; if (matrix_flat[2:0] !== 3'd6) $display("[TB] FAIL down_from_empty: got %0d required 6", matrix_flat[2:0]);
        else passes++;
        press(1);
        checks++; if (matrix_flat[2:0] !== 3'd1) $display("[TB] FAIL up_from_six: got %0d required 1", matrix_flat[2:0]);
        else passes++;
        press(3);
        checks++; if (cursor !== 2'd3) $display("[TB] FAIL left_wrap: got %0d required 3", cursor);
        else passes++;
        press(4);
        checks++; if (cursor !== 2'd0) $display("[TB] FAIL right_wrap: got %0d required 0", cursor);
        else passes++;
    endtask

    task automatic test_lose();
        logic q_e, q_e6; logic [35:0] fb_e6, fb_pre;
        do_start(12'o4321);
        for (int r = 0; r < 6; r++) begin
            play_row(12'o5555, q_e, q_e6, fb_e6, fb_pre);
            checks++; if (guess_num !== 3'(mguess) || feedback_flat !== '0)
                $display("[TB] FAIL lose_row%0d: guess %0d fb %h required %0d 0", r, guess_num, feedback_flat, mguess);
            else passes++;
        end
        checks++; if ({lose, win, q_Input, guess_num} !== 6'b100_101)
            $display("[TB] FAIL lose_status: got %b required 100101", {lose, win, q_Input, guess_num});
        else passes++;
        checks++; if (matrix_flat !== {6{12'o5555}}) $display("[TB] FAIL lose_matrix: got %h required %h", matrix_flat, {6{12'o5555}});
        else passes++;
    endtask

    task automatic test_reset_mid_check();
        do_start(12'o4321);
        fill_row(12'o3321);
        press(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if ({matrix_flat, feedback_flat, guess_num, cursor, q_Input, win, lose} !== '0)
            $display("[TB] FAIL async_reset: got %h required 0",
                     {matrix_flat, feedback_flat, guess_num, cursor, q_Input, win, lose});
        else passes++;
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if ({feedback_flat, guess_num, win, lose} !== '0)
            $display("[TB] FAIL no_resume_after_reset: got %h required 0", {feedback_flat, guess_num, win, lose});
        else passes++;
        do_start(12'o4327);
        press(1);
        checks++; if (q_Input !== 1'b0 || matrix_flat !== '0)
            $display("[TB] FAIL bad_secret_ignored: q_Input %b matrix %h required 0 0", q_Input, matrix_flat);
        else passes++;
    endtask

    task automatic test_random_games();
        logic q_e, q_e6; logic [35:0] fb_e6, fb_pre;
        logic [11:0] s, g;
        for (int game = 0; game < 5; game++) begin
            for (int c = 0; c < 4; c++) s[c*3 +: 3] = 3'($urandom_range(6, 1));
            do_start(s);
            while (minput) begin
                if ($urandom_range(3, 0) == 0) g = s;
                else for (int c = 0; c < 4; c++) g[c*3 +: 3] = 3'($urandom_range(6, 1));
                play_row(g, q_e, q_e6, fb_e6, fb_pre);
                checks++; if (q_e !== 1'b0 || q_e6 !== 1'b0 || fb_e6 !== fb_pre)
                    $display("[TB] FAIL rand_check_window: q %b%b fb %h required 00 %h", q_e, q_e6, fb_e6, fb_pre);
                else passes++;
                checks++; if (feedback_flat !== exp_fb() || matrix_flat !== exp_matrix())
                    $display("[TB] FAIL rand_board: fb %h matrix %h required %h %h",
                             feedback_flat, matrix_flat, exp_fb(), exp_matrix());
                else passes++;
                checks++; if ({guess_num, cursor, q_Input, win, lose} !== {3'(mguess), 2'(mcursor), minput, mwin, mlose})
                    $display("[TB] FAIL rand_status: got %b required %b", {guess_num, cursor, q_Input, win, lose},
                             {3'(mguess), 2'(mcursor), minput, mwin, mlose});
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_white_and_mixed();
        test_enter_ignored();
        test_peg_wrap();
        test_lose();
        test_reset_mid_check();
        test_random_games();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
